// File: rtl/nand_dqs_tap_calib_if.sv
// Signal bundle between the DQS tap calibrator, the controller init FSM,
// the read datapath that runs the test reads, and the DQS IOB delay load.
// The calibrator uses the master view; the surrounding logic uses the slave view.
interface nand_dqs_tap_calib_if;
   logic       cal_start;
   logic       cal_busy;
   logic       cal_done;
   logic       cal_fail;
   logic [4:0] cal_tap;
   logic [5:0] win_len;
   logic       rd_req;
   logic       rd_ack;
   logic       rd_pass;
   logic [4:0] dlyval_dqs;
   logic       dlyld_dqs;

   modport master (
      input  cal_start, rd_ack, rd_pass,
      output cal_busy, cal_done, cal_fail, cal_tap, win_len,
             rd_req, dlyval_dqs, dlyld_dqs
   );

   modport slave (
      output cal_start, rd_ack, rd_pass,
      input  cal_busy, cal_done, cal_fail, cal_tap, win_len,
             rd_req, dlyval_dqs, dlyld_dqs
   );
endinterface

// File: rtl/nand_dqs_tap_calib.sv
// Read-side DQS delay calibration for one NAND DQS lane.
// Sweeps IDELAY taps 0..31, runs a known-pattern test read at each tap,
// tracks the longest contiguous passing window (earliest wins on a tie)
// and finally loads the centre of that window, or DEFAULT_TAP when no
// window of at least MIN_WIN taps was found.
module nand_dqs_tap_calib #(
   parameter int DEFAULT_TAP = 16,
   parameter int LD_HOLD     = 4,
   parameter int SETTLE_CYC  = 16,
   parameter int RD_TIMEOUT  = 255,
   parameter int MIN_WIN     = 3
) (
   input logic                  clk0,
   input logic                  rst0_n,
   nand_dqs_tap_calib_if.master cal_if
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_TEST,
      ST_EVAL,
      ST_APPLY,
      ST_APPLY_SETTLE
   } state_t;

   // Terminal counts for the shared phase counter; all phases fit in 8 bits.
   localparam logic [7:0] LD_LAST      = 8'(LD_HOLD);
   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(RD_TIMEOUT - 1);
   localparam logic [4:0] DEF_TAP      = 5'(DEFAULT_TAP);
   localparam logic [5:0] MIN_LEN      = 6'(MIN_WIN);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cnt;
   logic [4:0] tap;
   logic [4:0] cur_start;
   logic [5:0] cur_len;
   logic [4:0] best_start;
   logic [5:0] best_len;
   logic       rd_ok;
   logic [4:0] cal_tap_q;
   logic [4:0] dlyval_q;
   logic [5:0] win_len_q;
   logic       done_q;
   logic       fail_q;
   logic [5:0] ev_cur_len;
   logic [4:0] ev_cur_start;
   logic [5:0] ev_best_len;
   logic [4:0] ev_best_start;
   logic [5:0] centre;
   logic [4:0] pick_tap;
   logic       load_phase;

   assign cal_if.cal_tap    = cal_tap_q;
   assign cal_if.dlyval_dqs = dlyval_q;
   assign cal_if.win_len    = win_len_q;
   assign cal_if.cal_done   = done_q;
   assign cal_if.cal_fail   = fail_q;

   // State register; reset aborts any sweep in progress without a final load.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and strobe decode; the first cycle of a load phase keeps the
   // strobe low so the tap value is already stable when dlyld_dqs rises.
   always_comb begin
      state_nxt        = state;
      load_phase       = 1'b0;
      cal_if.dlyld_dqs = 1'b0;
      cal_if.rd_req    = 1'b0;
      cal_if.cal_busy  = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (cal_if.cal_start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            load_phase = 1'b1;
            if (cnt == LD_LAST) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt == SETTLE_LAST) state_nxt = ST_TEST;
         end
         ST_TEST: begin
            cal_if.rd_req = 1'b1;
            if (cal_if.rd_ack || (cnt == TIMEOUT_LAST)) state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            state_nxt = (tap == 5'd31) ? ST_APPLY : ST_LOAD;
         end
         ST_APPLY: begin
            load_phase = 1'b1;
            if (cnt == LD_LAST) state_nxt = ST_APPLY_SETTLE;
         end
         ST_APPLY_SETTLE: begin
            if (cnt == SETTLE_LAST) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      cal_if.dlyld_dqs = load_phase && (cnt != 8'd0);
   end

   // Window tracker update for the current test result, plus the tap that
   // would be applied if this were the last step of the sweep.
   always_comb begin
      ev_cur_len    = rd_ok ? (cur_len + 6'd1) : 6'd0;
      ev_cur_start  = (rd_ok && (cur_len == 6'd0)) ? tap : cur_start;
      ev_best_len   = best_len;
      ev_best_start = best_start;
      if (ev_cur_len > best_len) begin
         ev_best_len   = ev_cur_len;
         ev_best_start = ev_cur_start;
      end
      centre   = {1'b0, ev_best_start} + ((ev_best_len - 6'd1) >> 1);
      pick_tap = (ev_best_len >= MIN_LEN) ? centre[4:0] : DEF_TAP;
   end

   // Phase counter restarts on every state change and idles at zero.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         cnt <= 8'd0;
      end else if (state_nxt != state) begin
         cnt <= 8'd0;
      end else if (state != ST_IDLE) begin
         cnt <= cnt + 8'd1;
      end
   end

   // Sweep datapath: tap stepping, test-result capture, window bookkeeping
   // and the sticky result outputs.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         tap        <= 5'd0;
         cur_start  <= 5'd0;
         cur_len    <= 6'd0;
         best_start <= 5'd0;
         best_len   <= 6'd0;
         rd_ok      <= 1'b0;
         cal_tap_q  <= DEF_TAP;
         dlyval_q   <= DEF_TAP;
         win_len_q  <= 6'd0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cal_if.cal_start) begin
                  tap        <= 5'd0;
                  dlyval_q   <= 5'd0;
                  cur_start  <= 5'd0;
                  cur_len    <= 6'd0;
                  best_start <= 5'd0;
                  best_len   <= 6'd0;
                  done_q     <= 1'b0;
                  fail_q     <= 1'b0;
               end
            end
            ST_TEST: begin
               if (cal_if.rd_ack) begin
                  rd_ok <= cal_if.rd_pass;
               end else if (cnt == TIMEOUT_LAST) begin
                  rd_ok <= 1'b0;
               end
            end
            ST_EVAL: begin
               cur_len    <= ev_cur_len;
               cur_start  <= ev_cur_start;
               best_len   <= ev_best_len;
               best_start <= ev_best_start;
               if (tap == 5'd31) begin
                  cal_tap_q <= pick_tap;
                  dlyval_q  <= pick_tap;
               end else begin
                  tap      <= tap + 5'd1;
                  dlyval_q <= tap + 5'd1;
               end
            end
            ST_APPLY_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  win_len_q <= best_len;
                  done_q    <= (best_len >= MIN_LEN);
                  fail_q    <= (best_len < MIN_LEN);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nand_dqs_tap_calib.sv
// Self-checking bench for the DQS tap calibrator: a table of directed
// pass-masks, randomized masks scored by a window-scan reference model,
// and hand-written sequences for latency, busy-edge and mid-sweep reset.
module tb_nand_dqs_tap_calib;

   localparam int DEFAULT_TAP = 16;
   localparam int LD_HOLD     = 4;
   localparam int SETTLE_CYC  = 16;
   localparam int RD_TIMEOUT  = 255;
   localparam int MIN_WIN     = 3;

   typedef struct {
      string       name;
      logic [31:0] mask;
      int          drop;
      bit          extra;
      int          exp_done;
      int          exp_fail;
      int          exp_win;
      int          exp_tap;
   } vec_t;

   typedef struct {
      int val;
      int len;
      bit ok;
   } load_t;

   logic        clk0 = 1'b0;
   logic        rst0_n;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] cur_mask;
   int          drop_tap;
   int          drop_hi;
   int          hi_cnt;
   int          req_idx;
   bit          fixed_delay;
   load_t       loads[$];
   bit          in_pulse;
   int          p_len;
   int          p_val;
   bit          p_ok;
   int          prev_val;
   vec_t        vecs[8];

   nand_dqs_tap_calib_if bif();

   nand_dqs_tap_calib #(
      .DEFAULT_TAP(DEFAULT_TAP),
      .LD_HOLD(LD_HOLD),
      .SETTLE_CYC(SETTLE_CYC),
      .RD_TIMEOUT(RD_TIMEOUT),
      .MIN_WIN(MIN_WIN)
   ) dut (
      .clk0(clk0),
      .rst0_n(rst0_n),
      .cal_if(bif)
   );

   always #5 clk0 = ~clk0;

   task automatic check_output(input string nm, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", nm, actual, expected);
      end
   endtask

   // Reference: scan every run of passing taps, keep the strictly longest.
   function automatic void ref_expect(input logic [31:0] mask, output int e_done,
                                      output int e_fail, output int e_win, output int e_tap);
      int  blen;
      int  bstart;
      int  len;
      bit  prev;
      blen = 0; bstart = 0; prev = 1'b0;
      for (int s = 0; s < 32; s++) begin
         if (mask[s] && !prev) begin
            len = 0;
            while ((s + len) < 32 && mask[s + len]) len++;
            if (len > blen) begin
               blen = len;
               bstart = s;
            end
         end
         prev = mask[s];
      end
      e_win  = blen;
      e_done = (blen >= MIN_WIN) ? 1 : 0;
      e_fail = 1 - e_done;
      e_tap  = (blen >= MIN_WIN) ? (bstart + (blen - 1) / 2) : DEFAULT_TAP;
   endfunction

   // Read datapath model: k-th request of a sweep is tap k; one tap may be starved.
   initial begin : read_model
      bif.rd_ack  = 1'b0;
      bif.rd_pass = 1'b0;
      forever begin
         @(negedge clk0);
         if (bif.rd_req === 1'b1) begin
            if (req_idx == drop_tap) begin
               hi_cnt = 0;
               while (bif.rd_req === 1'b1 && hi_cnt < 400) begin
                  hi_cnt++;
                  @(negedge clk0);
               end
               drop_hi = hi_cnt;
               bif.rd_ack  = 1'b1;
               bif.rd_pass = 1'b1;
               @(negedge clk0);
               bif.rd_ack  = 1'b0;
               bif.rd_pass = 1'b0;
            end else begin
               if (!fixed_delay) repeat ($urandom_range(0, 3)) @(negedge clk0);
               bif.rd_ack  = 1'b1;
               bif.rd_pass = (req_idx < 32) ? cur_mask[req_idx] : 1'b0;
               @(negedge clk0);
               bif.rd_ack  = 1'b0;
               bif.rd_pass = 1'($urandom_range(0, 1));
            end
            req_idx++;
         end
      end
   end

   // Record every IDELAY load: value, strobe width, and value stability around it.
   initial begin : load_monitor
      in_pulse = 1'b0;
      prev_val = 0;
      forever begin
         @(negedge clk0);
         if (bif.dlyld_dqs === 1'b1) begin
            if (!in_pulse) begin
               in_pulse = 1'b1;
               p_len = 0;
               p_val = int'(bif.dlyval_dqs);
               p_ok  = (prev_val == p_val);
            end
            p_len++;
            if (int'(bif.dlyval_dqs) != p_val) p_ok = 1'b0;
         end else if (in_pulse) begin
            in_pulse = 1'b0;
            if (int'(bif.dlyval_dqs) != p_val) p_ok = 1'b0;
            loads.push_back('{val: p_val, len: p_len, ok: p_ok});
         end
         prev_val = int'(bif.dlyval_dqs);
      end
   end

   // Run one full calibration against a pass mask and check every result.
   task automatic apply_stimulus(input string nm, input logic [31:0] mask, input int drop,
                                 input bit extra, input int e_done, input int e_fail,
                                 input int e_win, input int e_tap);
      int cyc;
      int bad_seq;
      int bad_shape;
      cur_mask = mask;
      drop_tap = drop;
      drop_hi  = -1;
      req_idx  = 0;
      loads.delete();
      bif.cal_start = 1'b1;
      @(negedge clk0);
      bif.cal_start = 1'b0;
      check_output({nm, ".busy_after_start"}, bif.cal_busy, 1);
      check_output({nm, ".done_cleared"}, bif.cal_done, 0);
      check_output({nm, ".fail_cleared"}, bif.cal_fail, 0);
      cyc = 0;
      while (bif.cal_busy === 1'b1 && cyc < 10000) begin
         cyc++;
         bif.cal_start = (extra && cyc == 200);
         @(negedge clk0);
      end
      bif.cal_start = 1'b0;
      check_output({nm, ".finished"}, (bif.cal_busy === 1'b0), 1);
      check_output({nm, ".cal_done"}, bif.cal_done, e_done);
      check_output({nm, ".cal_fail"}, bif.cal_fail, e_fail);
      check_output({nm, ".win_len"}, bif.win_len, e_win);
      check_output({nm, ".cal_tap"}, bif.cal_tap, e_tap);
      check_output({nm, ".dlyval_final"}, bif.dlyval_dqs, e_tap);
      check_output({nm, ".rd_req_idle"}, bif.rd_req, 0);
      check_output({nm, ".load_count"}, loads.size(), 33);
      bad_seq = 0;
      bad_shape = 0;
      foreach (loads[i]) begin
         if (loads[i].val != ((i < 32) ? i : e_tap)) bad_seq++;
         if (loads[i].len != LD_HOLD || !loads[i].ok) bad_shape++;
      end
      check_output({nm, ".load_sequence_errors"}, bad_seq, 0);
      check_output({nm, ".load_strobe_errors"}, bad_shape, 0);
      if (drop >= 0) check_output({nm, ".timeout_cycles"}, drop_hi, RD_TIMEOUT);
      repeat (2) @(negedge clk0);
   endtask

   initial begin : main
      logic [31:0] m;
      logic [31:0] eff;
      int          drop;
      int          nw;
      int          s;
      int          l;
      int          e_done;
      int          e_fail;
      int          e_win;
      int          e_tap;
      int          cyc;

      vecs[0] = '{"win10_20",       32'h001FFC00, -1, 1'b0, 1, 0, 11, 15};
      vecs[1] = '{"never_pass",     32'h00000000, -1, 1'b0, 0, 1,  0, 16};
      vecs[2] = '{"longer_second",  32'h0FF00038, -1, 1'b0, 1, 0,  8, 23};
      vecs[3] = '{"tie_earlier",    32'h00001E3C, -1, 1'b0, 1, 0,  4,  3};
      vecs[4] = '{"all_pass",       32'hFFFFFFFF, -1, 1'b1, 1, 0, 32, 15};
      vecs[5] = '{"timeout_tap14",  32'h001FFC00, 14, 1'b0, 1, 0,  6, 17};
      vecs[6] = '{"min_win_top",    32'hE0000000, -1, 1'b0, 1, 0,  3, 30};
      vecs[7] = '{"below_min",      32'h00000003, -1, 1'b0, 0, 1,  2, 16};

      fixed_delay   = 1'b0;
      drop_tap      = -1;
      req_idx       = 0;
      cur_mask      = '0;
      bif.cal_start = 1'b0;
      rst0_n        = 1'b0;
      repeat (3) @(negedge clk0);
      check_output("reset.dlyval_dqs", bif.dlyval_dqs, DEFAULT_TAP);
      check_output("reset.cal_tap", bif.cal_tap, DEFAULT_TAP);
      check_output("reset.dlyld_dqs", bif.dlyld_dqs, 0);
      check_output("reset.rd_req", bif.rd_req, 0);
      check_output("reset.cal_busy", bif.cal_busy, 0);
      check_output("reset.cal_done", bif.cal_done, 0);
      check_output("reset.cal_fail", bif.cal_fail, 0);
      check_output("reset.win_len", bif.win_len, 0);
      rst0_n = 1'b1;
      repeat (2) @(negedge clk0);

      for (int v = 0; v < 8; v++) begin
         $display("[TB] vector %s", vecs[v].name);
         apply_stimulus(vecs[v].name, vecs[v].mask, vecs[v].drop, vecs[v].extra,
                        vecs[v].exp_done, vecs[v].exp_fail, vecs[v].exp_win, vecs[v].exp_tap);
      end

      for (int r = 0; r < 10; r++) begin
         m = '0;
         nw = int'($urandom_range(1, 3));
         for (int w = 0; w < nw; w++) begin
            s = int'($urandom_range(0, 31));
            l = int'($urandom_range(1, 12));
            for (int b = s; b < s + l && b < 32; b++) m[b] = 1'b1;
         end
         drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1;
         eff = m;
         if (drop >= 0) eff[drop] = 1'b0;
         ref_expect(eff, e_done, e_fail, e_win, e_tap);
         $display("[TB] random %0d mask=%08h drop=%0d", r, m, drop);
         apply_stimulus($sformatf("rand%0d", r), m, drop, 1'b0, e_done, e_fail, e_win, e_tap);
      end

      // Immediate acks: fixed latency, and a start in the busy-drop cycle is ignored.
      fixed_delay = 1'b1;
      cur_mask = 32'h001FFC00;
      drop_tap = -1;
      req_idx  = 0;
      loads.delete();
      bif.cal_start = 1'b1;
      @(negedge clk0);
      bif.cal_start = 1'b0;
      cyc = 0;
      while (bif.cal_busy === 1'b1 && cyc < 2000) begin
         cyc++;
         if (cyc == 33 * 0 + 32 * (LD_HOLD + SETTLE_CYC + 3) + LD_HOLD + SETTLE_CYC + 1)
            bif.cal_start = 1'b1;
         @(negedge clk0);
      end
      bif.cal_start = 1'b0;
      check_output("latency.busy_cycles", cyc, 32 * (LD_HOLD + SETTLE_CYC + 3) + LD_HOLD + SETTLE_CYC + 1);
      repeat (3) @(negedge clk0);
      check_output("busy_edge_start.busy", bif.cal_busy, 0);
      check_output("busy_edge_start.done", bif.cal_done, 1);
      fixed_delay = 1'b0;

      // Asynchronous reset during SETTLE at tap 9, then a clean restart.
      cur_mask = 32'h001FFC00;
      drop_tap = -1;
      req_idx  = 0;
      loads.delete();
      bif.cal_start = 1'b1;
      @(negedge clk0);
      bif.cal_start = 1'b0;
      cyc = 0;
      while (loads.size() < 10 && cyc < 3000) begin
         cyc++;
         @(negedge clk0);
      end
      check_output("midreset.reached_tap9", loads.size(), 10);
      repeat (2) @(negedge clk0);
      check_output("midreset.pre_tap", bif.dlyval_dqs, 9);
      #1 rst0_n = 1'b0;
      #1;
      check_output("midreset.rd_req", bif.rd_req, 0);
      check_output("midreset.dlyld_dqs", bif.dlyld_dqs, 0);
      check_output("midreset.dlyval_dqs", bif.dlyval_dqs, DEFAULT_TAP);
      check_output("midreset.cal_busy", bif.cal_busy, 0);
      @(negedge clk0);
      rst0_n = 1'b1;
      req_idx = 0;
      repeat (2) @(negedge clk0);
      apply_stimulus("restart", 32'h001FFC00, -1, 1'b0, 1, 0, 11, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
